bcd_exc_3: RTL and testbench
============================

BCD_EXC_3 -- requirements
Module: bcd_exc_3

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on BTN (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required by the debounce filter (legal range 1..65535); used only when BCD_EXC_3_DEBOUNCE_EN is defined.
REQ-003 clk  input  1  single clock; all flops rise-edge triggered.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 BTN  input  4  BCD digit from buttons, asynchronous to clk, bit 3 = MSB.
REQ-006 LED  output  4  registered Excess-3 code of the conditioned BTN value.
REQ-007 ERR  output  1  registered flag, high while the conditioned BTN value is not a legal BCD digit (10..15).

Function
REQ-008 BTN SHALL pass through a SYNC_STAGES-deep flop chain per bit before any use.
REQ-009 For conditioned value d in 0..9, LED SHALL equal d+3 (4-bit, no overflow possible), and ERR SHALL be 0.
REQ-010 For d in 10..15, LED SHALL be 4'b0000 and ERR SHALL be 1.
REQ-011 LED and ERR SHALL be driven directly from flops, with no combinational path from BTN.
REQ-012 Without debounce, LED/ERR SHALL reflect a BTN change exactly SYNC_STAGES+1 clk edges after the first edge that samples the new BTN value.
REQ-013 With debounce, the filtered value SHALL update only after the synchronized value has differed from the filtered value and held the same value for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 With debounce, any change of the synchronized value before the count completes SHALL restart the count. Latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
REQ-015 Holding BTN constant SHALL hold LED/ERR constant. No glitches SHALL occur between valid codes.

Reset
REQ-016 rst_n low SHALL immediately clear all synchronizer, debounce, LED and ERR flops to 0, regardless of clk.
REQ-017 Deassertion SHALL be synchronized internally. The first functional edge is the first rising clk edge after rst_n goes high.
REQ-018 rst_n asserted mid-operation SHALL abort any debounce count. After release, LED SHALL show 4'b0011 once latency elapses if BTN=0.

Configuration
REQ-019 Macro BCD_EXC_3_DEBOUNCE_EN defined: the debounce filter of REQ-013/014 SHALL be compiled in between the synchronizer and the conversion register.
REQ-020 Macro BCD_EXC_3_DEBOUNCE_EN undefined: no debounce logic SHALL exist, and DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-021 Package bcd_exc_3_pkg SHALL hold EXC3_OFFSET=3, BCD_MAX=9, INVALID_LED=4'b0000 and the 4-bit digit typedef.
REQ-022 Synchronizer plus optional debounce SHALL be one sub-module, bcd_exc_3_cond, instantiated once for the 4-bit bus.
REQ-023 Conversion and output registers SHALL reside in bcd_exc_3.

Verification
REQ-024 Reset: rst_n=0 with BTN=4'h7 -> LED=0000, ERR=0 immediately, without a clk edge.
REQ-025 Sweep BTN 0..15, each held 20 cycles -> LED 3,4,...,12 with ERR=0 for 0..9, and LED=0, ERR=1 for 10..15.
REQ-026 Latency (no debounce): BTN 0->5 -> LED changes 0011->1000 exactly 3 cycles later.
REQ-027 Debounce: BTN toggles 2<->3 every 2 cycles, DEBOUNCE_CYCLES=4 -> LED holds its prior value; BTN then stable at 3 -> LED=0110 after 2+4+1 cycles.
REQ-028 Mid-operation reset: BTN=9, pulse rst_n low for 1 cycle -> LED=0000 during reset, then LED=1100 after latency.
REQ-029 Boundary: BTN 9->10 -> LED 1100->0000 and ERR 0->1 on the same edge.

Source files
------------

// File: rtl/bcd_exc_3_pkg.sv
// Shared constants and digit type for the BCD to Excess-3 button/LED block.
// Optional debounce is selected with the BCD_EXC_3_DEBOUNCE_EN macro.
package bcd_exc_3_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t EXC3_OFFSET = 4'd3;
  localparam digit_t BCD_MAX     = 4'd9;
  localparam digit_t INVALID_LED = 4'b0000;

  function automatic logic is_bcd(input digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_exc_3_cond.sv
// Input conditioning: SYNC_STAGES-deep synchronizer, plus a stability filter
// when BCD_EXC_3_DEBOUNCE_EN is defined.
module bcd_exc_3_cond
  import bcd_exc_3_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  digit_t raw,
  output digit_t cond
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_params
    $error("bcd_exc_3_cond: parameter out of range");
  end

  digit_t sync_q [SYNC_STAGES];
  digit_t sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef BCD_EXC_3_DEBOUNCE_EN
  localparam logic [16:0] DB_TARGET = 17'(DEBOUNCE_CYCLES);

  digit_t      filt;
  digit_t      prev;
  logic [15:0] cnt;
  logic [16:0] next_cnt;

  // A run of identical samples extends the count; any change restarts at 1.
  always_comb begin
    next_cnt = 17'd1;
    if (cnt != '0 && sync == prev) next_cnt = {1'b0, cnt} + 17'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= sync;
      if (sync == filt) begin
        cnt <= '0;
      end else if (next_cnt == DB_TARGET) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= next_cnt[15:0];
      end
    end
  end

  assign cond = filt;
`else
  assign cond = sync;
`endif

endmodule

// File: rtl/bcd_exc_3.sv
// BCD button digit to registered Excess-3 LED code with invalid-digit flag.
// Build with BCD_EXC_3_DEBOUNCE_EN to insert the debounce filter.
module bcd_exc_3
  import bcd_exc_3_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] BTN,
  output logic [3:0] LED,
  output logic       ERR
);

  digit_t d;

  bcd_exc_3_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (BTN),
    .cond (d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LED <= '0;
      ERR <= 1'b0;
    end else if (is_bcd(d)) begin
      LED <= d + EXC3_OFFSET;
      ERR <= 1'b0;
    end else begin
      LED <= INVALID_LED;
      ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_exc_3.sv
// Directed bench for bcd_exc_3; debounce sequence is active when built with
// BCD_EXC_3_DEBOUNCE_EN.
module tb_bcd_exc_3;

`ifdef BCD_EXC_3_DEBOUNCE_EN
  localparam int LAT = 2 + 4 + 1;
`else
  localparam int LAT = 2 + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] BTN;
  logic [3:0] LED;
  logic       ERR;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] led;
    logic       err;
  } vec_t;

  vec_t vecs [16];

  bcd_exc_3 #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .BTN  (BTN),
    .LED  (LED),
    .ERR  (ERR)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  4'b0011, 1'b0};
    vecs[1]  = '{4'd1,  4'b0100, 1'b0};
    vecs[2]  = '{4'd2,  4'b0101, 1'b0};
    vecs[3]  = '{4'd3,  4'b0110, 1'b0};
    vecs[4]  = '{4'd4,  4'b0111, 1'b0};
    vecs[5]  = '{4'd5,  4'b1000, 1'b0};
    vecs[6]  = '{4'd6,  4'b1001, 1'b0};
    vecs[7]  = '{4'd7,  4'b1010, 1'b0};
    vecs[8]  = '{4'd8,  4'b1011, 1'b0};
    vecs[9]  = '{4'd9,  4'b1100, 1'b0};
    vecs[10] = '{4'd10, 4'b0000, 1'b1};
    vecs[11] = '{4'd11, 4'b0000, 1'b1};
    vecs[12] = '{4'd12, 4'b0000, 1'b1};
    vecs[13] = '{4'd13, 4'b0000, 1'b1};
    vecs[14] = '{4'd14, 4'b0000, 1'b1};
    vecs[15] = '{4'd15, 4'b0000, 1'b1};

    rst_n = 1'b0;
    BTN   = 4'd0;
    #2;
    check("reset_led", LED, 4'b0000);
    check("reset_err", {3'b0, ERR}, 4'd0);

    step(1);
    rst_n = 1'b1;
    BTN   = 4'd7;
    step(LAT + 2);
    check("pre_reset_led", LED, 4'b1010);

    // Asynchronous assertion: outputs must clear with no clock edge.
    rst_n = 1'b0;
    #1;
    check("async_reset_led", LED, 4'b0000);
    check("async_reset_err", {3'b0, ERR}, 4'd0);
    step(1);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      BTN = vecs[i].btn;
      step(10);
      check($sformatf("hold_led_%0d", i), LED, vecs[i].led);
      step(10);
      check($sformatf("sweep_led_%0d", i), LED, vecs[i].led);
      check($sformatf("sweep_err_%0d", i), {3'b0, ERR}, {3'b0, vecs[i].err});
    end

    BTN = 4'd0;
    step(20);
    check("lat_before", LED, 4'b0011);
    BTN = 4'd5;
    step(LAT - 1);
    check("lat_early", LED, 4'b0011);
    step(1);
    check("lat_exact", LED, 4'b1000);

    BTN = 4'd9;
    step(20);
    check("bound_9_led", LED, 4'b1100);
    BTN = 4'd10;
    step(LAT - 1);
    check("bound_early_led", LED, 4'b1100);
    check("bound_early_err", {3'b0, ERR}, 4'd0);
    step(1);
    check("bound_10_led", LED, 4'b0000);
    check("bound_10_err", {3'b0, ERR}, 4'd1);

    BTN = 4'd9;
    step(20);
    check("midrst_pre", LED, 4'b1100);
    rst_n = 1'b0;
    #1;
    check("midrst_during", LED, 4'b0000);
    step(1);
    check("midrst_edge", LED, 4'b0000);
    rst_n = 1'b1;
    step(LAT - 1);
    check("midrst_early", LED, 4'b0011);
    step(1);
    check("midrst_after", LED, 4'b1100);

`ifdef BCD_EXC_3_DEBOUNCE_EN
    BTN = 4'd2;
    step(20);
    check("db_base", LED, 4'b0101);
    for (int k = 0; k < 5; k++) begin
      BTN = 4'd3;
      step(2);
      check($sformatf("db_toggle_hi_%0d", k), LED, 4'b0101);
      BTN = 4'd2;
      step(2);
      check($sformatf("db_toggle_lo_%0d", k), LED, 4'b0101);
    end
    BTN = 4'd3;
    step(LAT - 1);
    check("db_stable_early", LED, 4'b0101);
    step(1);
    check("db_stable_done", LED, 4'b0110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
